// File: rtl/irq_source_ctrl.sv
// Machine-level interrupt source: memory-mapped mtime/mtimecmp/msip,
// external interrupt synchroniser and edge latch, and a prioritised
// interrupt request (valid + cause) toward the CSR trap-entry logic.
module irq_source_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
  parameter int unsigned TICK_DIV    = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_strb,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  input  logic        ext_irq,
  output logic        irq_valid,
  output logic [1:0]  irq_code,
  input  logic        irq_ack,
  output logic [63:0] mtime_out
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    IRQ_NONE  = 2'd0,
    IRQ_SW    = 2'd1,
    IRQ_TIMER = 2'd2,
    IRQ_EXT   = 2'd3
  } irq_code_e;

  // Register offsets inside the block
  localparam logic [31:0] OFF_MSIP     = 32'h0000_0000;
  localparam logic [31:0] OFF_MTIMECMP = 32'h0000_4000;
  localparam logic [31:0] OFF_MTIME    = 32'h0000_BFF8;

  // Replace only the byte lanes whose strobe is set
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_v,
                                              input logic [63:0] new_v,
                                              input logic [7:0]  strb);
    logic [63:0] res;
    res = old_v;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return res;
  endfunction

  logic [PW-1:0]          presc_q, presc_d;
  logic [63:0]            mtime_q, mtime_d;
  logic [63:0]            mtimecmp_q, mtimecmp_d;
  logic                   msip_q, msip_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [63:0]            resp_rdata_q, resp_rdata_d;
  logic                   resp_err_q, resp_err_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ext_prev_q;
  logic                   tip_q, sip_q, eip_q, eip_d;

  logic [31:0] offset;
  logic        sel_msip, sel_cmp, sel_time, hit, wr, rd, tick, ext_rise, ack_ext;
  irq_code_e   code_w;

  assign offset   = req_addr - BASE_ADDR;
  assign sel_msip = (offset == OFF_MSIP);
  assign sel_cmp  = (offset == OFF_MTIMECMP);
  assign sel_time = (offset == OFF_MTIME);
  assign hit      = sel_msip | sel_cmp | sel_time;
  assign wr       = req_valid & req_write & hit;
  assign rd       = req_valid & ~req_write & hit;
  assign tick     = (presc_q == PW'(TICK_DIV - 1));

  // Prescaler, timer registers, msip and MMIO response next-state
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
    presc_d      = tick ? '0 : presc_q + PW'(1);
    mtime_d      = mtime_q;
    mtimecmp_d   = mtimecmp_q;
    msip_d       = msip_q;
    resp_valid_d = req_valid;
    resp_err_d   = req_valid & ~hit;
    resp_rdata_d = '0;

    // A software write to mtime overrides the tick in the same cycle
    if (wr && sel_time)   mtime_d = merge_bytes(mtime_q, req_wdata, req_strb);
    else if (tick)        mtime_d = mtime_q + 64'd1;
    if (wr && sel_cmp)    mtimecmp_d = merge_bytes(mtimecmp_q, req_wdata, req_strb);
    if (wr && sel_msip && req_strb[0]) msip_d = req_wdata[0];

    // Reads see the register values from before any same-cycle write
    if (rd) begin
      if (sel_msip)     resp_rdata_d = {63'd0, msip_q};
      else if (sel_cmp) resp_rdata_d = mtimecmp_q;
      else              resp_rdata_d = mtime_q;
    end
  end

  // Highest-priority pending source drives the request to the CSR unit
  always_comb begin
    code_w = IRQ_NONE;
    if (eip_q)      code_w = IRQ_EXT;
    else if (sip_q) code_w = IRQ_SW;
    else if (tip_q) code_w = IRQ_TIMER;
  end

  assign ext_rise = sync_q[SYNC_STAGES-1] & ~ext_prev_q;
  assign ack_ext  = irq_ack & (code_w == IRQ_EXT);
  // A fresh edge coinciding with the clearing ack keeps the source pending
  assign eip_d    = ext_rise | (eip_q & ~ack_ext);

  // Timer, msip and MMIO response state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q      <= '0;
      mtime_q      <= '0;
      mtimecmp_q   <= '1;
      msip_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      presc_q      <= presc_d;
      mtime_q      <= mtime_d;
      mtimecmp_q   <= mtimecmp_d;
      msip_q       <= msip_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // External line synchroniser, edge detector and registered pending bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= '0;
      ext_prev_q <= 1'b0;
      tip_q      <= 1'b0;
      sip_q      <= 1'b0;
      eip_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], ext_irq};
      ext_prev_q <= sync_q[SYNC_STAGES-1];
      tip_q      <= (mtime_q >= mtimecmp_q);
      sip_q      <= msip_q;
      eip_q      <= eip_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign irq_valid  = (code_w != IRQ_NONE);
  assign irq_code   = code_w;
  assign mtime_out  = mtime_q;

endmodule

// File: tb/tb_irq_source_ctrl.sv
// Scoreboard bench for irq_source_ctrl: two instances (TICK_DIV 1 and 4)
// share the stimulus; a reference model predicts responses and interrupt
// outputs, and a monitor compares them against the DUT outputs.
module tb_irq_source_ctrl;

  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam int SYNC = 2;
  localparam int TICKS [2] = '{1, 4};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_strb = '0;
  logic        ext_irq = 1'b0, irq_ack = 1'b0;

  logic        rv0, re0, iv0, rv1, re1, iv1;
  logic [63:0] rd0, mt0, rd1, mt1;
  logic [1:0]  ic0, ic1;

  always #5 clk = ~clk;

  irq_source_ctrl #(.BASE_ADDR(BASE), .TICK_DIV(1), .SYNC_STAGES(SYNC)) dut0 (
    .clk(clk), .reset(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .resp_valid(rv0), .resp_rdata(rd0), .resp_err(re0), .ext_irq(ext_irq),
    .irq_valid(iv0), .irq_code(ic0), .irq_ack(irq_ack), .mtime_out(mt0));

  irq_source_ctrl #(.BASE_ADDR(BASE), .TICK_DIV(4), .SYNC_STAGES(SYNC)) dut1 (
    .clk(clk), .reset(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .resp_valid(rv1), .resp_rdata(rd1), .resp_err(re1), .ext_irq(ext_irq),
    .irq_valid(iv1), .irq_code(ic1), .irq_ack(irq_ack), .mtime_out(mt1));

  typedef struct {int due; logic [63:0] rdata; logic err;} resp_t;
  typedef struct {int due; logic v; logic [1:0] code; logic [63:0] mtime;} irq_t;
  resp_t rq0[$], rq1[$];
  irq_t  iq0[$], iq1[$];

  int vectors = 0, miscompares = 0;
  int n_edges = 0;

  // Reference model state
  logic [63:0] m_mtime [2];
  logic [63:0] m_cmp;
  logic        m_msip, m_sip, m_eip;
  logic        m_tip [2];
  logic [15:0] ext_hist;   // bit j = pin value sampled j+1 edges ago
  int          m_edges;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n, input logic [7:0] s);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = s[i] ? n[i*8 +: 8] : o[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [1:0] model_code(input int k);
    if (m_eip) return 2'd3;
    if (m_sip) return 2'd1;
    if (m_tip[k]) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_mtime[0] = '0; m_mtime[1] = '0; m_cmp = '1; m_msip = 1'b0;
    m_sip = 1'b0; m_eip = 1'b0; m_tip[0] = 1'b0; m_tip[1] = 1'b0;
    ext_hist = '0; m_edges = 0;
  endtask

  // One clock edge: predict responses, advance model, queue expectations
  task automatic step();
    logic [31:0] off;
    logic        err, ack_clr, rise;
    logic [63:0] rdat;
    logic [63:0] nt [2];
    logic        ntip [2];
    resp_t       r;
    irq_t        q;
    @(posedge clk);
    off = req_addr - BASE;
    err = !(off == 32'h0 || off == 32'h4000 || off == 32'hBFF8);
    for (int k = 0; k < 2; k++) begin
      rdat = '0;
      if (!req_write && !err)
        rdat = (off == 32'h0) ? {63'd0, m_msip} : (off == 32'h4000) ? m_cmp : m_mtime[k];
      r = '{n_edges + 1, rdat, err};
      if (req_valid) begin
        if (k == 0) rq0.push_back(r); else rq1.push_back(r);
      end
    end
    ack_clr = irq_ack && m_eip;
    rise    = ext_hist[SYNC-1] && !ext_hist[SYNC];
    for (int k = 0; k < 2; k++) begin
      ntip[k] = m_mtime[k] >= m_cmp;
      nt[k]   = m_mtime[k];
      if (req_valid && req_write && off == 32'hBFF8) nt[k] = merge(m_mtime[k], req_wdata, req_strb);
      else if (m_edges % TICKS[k] == TICKS[k] - 1)   nt[k] = m_mtime[k] + 64'd1;
    end
    m_sip = m_msip;
    m_eip = rise || (m_eip && !ack_clr);
    if (req_valid && req_write && off == 32'h4000) m_cmp = merge(m_cmp, req_wdata, req_strb);
    if (req_valid && req_write && off == 32'h0 && req_strb[0]) m_msip = req_wdata[0];
    for (int k = 0; k < 2; k++) begin
      m_mtime[k] = nt[k];
      m_tip[k]   = ntip[k];
    end
    ext_hist = {ext_hist[14:0], ext_irq};
    m_edges++;
    n_edges++;
    for (int k = 0; k < 2; k++) begin
      q = '{n_edges, (model_code(k) != 2'd0), model_code(k), m_mtime[k]};
      if (k == 0) iq0.push_back(q); else iq1.push_back(q);
    end
  endtask

  // Drive one cycle from a negedge; returns at the following negedge
  task automatic cyc(input logic v, input logic w, input logic [31:0] off,
                     input logic [63:0] d, input logic [7:0] s, input logic ack);
    req_valid = v; req_write = w; req_addr = BASE + off;
    req_wdata = d; req_strb = s; irq_ack = ack;
    step();
    @(negedge clk);
    req_valid = 1'b0; irq_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 32'h0, 64'h0, 8'h0, 1'b0);
  endtask
  task automatic wr(input logic [31:0] off, input logic [63:0] d, input logic [7:0] s);
    cyc(1'b1, 1'b1, off, d, s, 1'b0);
  endtask
  task automatic rd(input logic [31:0] off);
    cyc(1'b1, 1'b0, off, 64'h0, 8'h0, 1'b0);
  endtask
  task automatic ack();
    cyc(1'b0, 1'b0, 32'h0, 64'h0, 8'h0, 1'b1);
  endtask

  // Monitor: pop and compare whenever an expectation falls due
  task automatic mon(input int k, input logic rv, input logic [63:0] rdat, input logic re,
                     input logic iv, input logic [1:0] ic, input logic [63:0] mt);
    resp_t e;
    irq_t  q;
    bit    got;
    got = 0;
    if (k == 0 && rq0.size() > 0 && rq0[0].due <= n_edges) begin e = rq0.pop_front(); got = 1; end
    if (k == 1 && rq1.size() > 0 && rq1[0].due <= n_edges) begin e = rq1.pop_front(); got = 1; end
    if (got) begin
      check($sformatf("resp_valid[%0d]", k), rv, 1'b1);
      check($sformatf("resp_rdata[%0d]", k), rdat, e.rdata);
      check($sformatf("resp_err[%0d]", k), re, e.err);
    end else if (rv) begin
      check($sformatf("spurious resp_valid[%0d]", k), rv, 1'b0);
    end
    got = 0;
    if (k == 0 && iq0.size() > 0 && iq0[0].due <= n_edges) begin q = iq0.pop_front(); got = 1; end
    if (k == 1 && iq1.size() > 0 && iq1[0].due <= n_edges) begin q = iq1.pop_front(); got = 1; end
    if (got) begin
      check($sformatf("irq_valid[%0d]", k), iv, q.v);
      check($sformatf("irq_code[%0d]", k), ic, q.code);
      check($sformatf("mtime_out[%0d]", k), mt, q.mtime);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, rv0, rd0, re0, iv0, ic0, mt0);
      mon(1, rv1, rd1, re1, iv1, ic1, mt1);
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, " resp_valid0"}, rv0, 1'b0);  check({tag, " resp_valid1"}, rv1, 1'b0);
    check({tag, " resp_rdata0"}, rd0, 64'h0); check({tag, " resp_rdata1"}, rd1, 64'h0);
    check({tag, " resp_err0"}, re0, 1'b0);    check({tag, " resp_err1"}, re1, 1'b0);
    check({tag, " irq_valid0"}, iv0, 1'b0);   check({tag, " irq_valid1"}, iv1, 1'b0);
    check({tag, " irq_code0"}, ic0, 2'd0);    check({tag, " irq_code1"}, ic1, 2'd0);
    check({tag, " mtime0"}, mt0, 64'h0);      check({tag, " mtime1"}, mt1, 64'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] offs [6];
    logic [31:0] off;
    logic [63:0] d;
    offs = '{32'h0, 32'h4000, 32'hBFF8, 32'h8, 32'h4004, 32'hBFFC};

    // Reset held three cycles with the external line high
    model_reset();
    ext_irq = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    idle(1);
    check("mtime after first edge", mt0, 64'd1);
    idle(3);
    check("ext pending after reset", ic0, 2'd3);
    ext_irq = 1'b0;
    ack();

    // Timer fires once mtime reaches mtimecmp, withdraws when cmp is raised
    idle(10);
    wr(32'h4000, 64'h20, 8'hFF);
    idle(25);
    check("timer code", ic0, 2'd2);
    check("slow timer not yet", iv1, 1'b0);
    wr(32'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    idle(3);
    check("timer withdrawn", iv0, 1'b0);

    // Priority: software over timer, external over software
    wr(32'h4000, 64'h0, 8'hFF);
    idle(2);
    wr(32'h0, 64'h1, 8'hFF);
    idle(3);
    check("sw over timer", ic0, 2'd1);
    ext_irq = 1'b1;
    idle(4);
    check("ext over sw", ic0, 2'd3);
    ack();
    idle(2);
    check("back to sw after ack", ic0, 2'd1);
    ack();
    idle(2);
    check("sw survives ack", ic0, 2'd1);
    ext_irq = 1'b0;
    wr(32'h0, 64'h0, 8'h01);

    // MMIO reads, partial strobes, decode errors, back-to-back traffic
    rd(32'hBFF8);
    wr(32'h4000, 64'h1122, 8'h01);
    rd(32'h4000);
    rd(32'h8);
    rd(32'h0);
    wr(32'h0, 64'hFF, 8'hFE);
    rd(32'h0);
    wr(32'h4004, 64'h55, 8'hFF);
    rd(32'h4000);

    // mtime wrap and write-over-tick
    wr(32'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    idle(1);
    check("mtime wrap", mt0, 64'h0);
    wr(32'hBFF8, 64'h1000, 8'hFF);
    check("write beats tick", mt0, 64'h1000);
    rd(32'hBFF8);

    // Ack with nothing pending changes nothing
    wr(32'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    idle(3);
    ack();
    idle(2);
    check("idle ack no effect", iv0, 1'b0);
    check("idle ack no effect slow", iv1, 1'b0);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(15) == 0) ext_irq = ~ext_irq;
      off = ($urandom_range(7) == 0) ? $urandom() : offs[$urandom_range(5)];
      d   = ($urandom_range(1) == 0) ? {$urandom(), $urandom()} : 64'($urandom_range(4000));
      cyc($urandom_range(1) == 1, $urandom_range(1) == 1, off, d,
          8'($urandom_range(255)), $urandom_range(7) == 0);
    end
    ext_irq = 1'b0;
    idle(2);
    check("resp queue 0 drained", rq0.size(), 0);
    check("resp queue 1 drained", rq1.size(), 0);

    // Reset while a read is in flight drops its response
    req_valid = 1'b1; req_write = 1'b0; req_addr = BASE + 32'hBFF8;
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_reset_outputs("mid reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
